nanci_edge_tx: RTL and testbench
================================

Name: nanci_edge_tx

Overview:
- Transmit end of the PE neighbour link.
- Emulates a neighbour PE at the mesh boundary (or in a standalone PE bench) by presenting a scripted stream of {addr,data} words on one link, i.e. the word a PE reads through i_PE_l/r/u/d.
- Words are buffered in a small FIFO, launched on i_start, and each is held for a programmable number of cycles to match the PE compute step.
- When no word is being sent, the link idles at MAX_INT so that idle slots sort last.

Parameters:
ADDR_WIDTH, 3, address field width
DATA_WIDTH, 3, data field width
DEPTH, 8, FIFO entries (power of 2, >=2)
HOLD_CYCLES, 1, cycles each word stays on o_PE (>=1)
MAX_INT, all-ones of ADDR_WIDTH+DATA_WIDTH (6'b111_111 at defaults), idle link value

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_wr_en  in  1  write strobe
i_wr_word  in  W=ADDR_WIDTH+DATA_WIDTH  word to buffer, {addr,data}
i_start  in  1  begin transmission (single-cycle pulse)
i_stop  in  1  abort transmission
o_PE  out  W  link word to neighbour PE
o_valid  out  1  o_PE carries a buffered word
o_full  out  1  FIFO cannot accept a write
o_empty  out  1  count==0
o_overflow  out  1  sticky: a write was attempted while full
o_done  out  1  one-cycle pulse at the end of the stream

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: o_PE=MAX_INT, o_valid=0, o_full=0, o_empty=1, o_overflow=0, o_done=0, state=IDLE, pointers=0, count=0.
- Reset mid-stream discards all buffered words.
- FIFO: circular buffer with wr_ptr, rd_ptr and count (log2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
- Write: i_wr_en && !o_full stores the word and increments count.
- Write while full: dropped, o_overflow<=1 until rst.
- Write and pop in the same cycle: count unchanged.
- o_full = (count==DEPTH); o_empty = (count==0). Both are combinational from count.
- States: IDLE, SEND.
- IDLE:
  - o_PE=MAX_INT, o_valid=0.
  - i_start with count>0: pop the head into the o_PE register and go to SEND. The word is visible at t+1 (one-cycle latency).
  - i_start with count==0: o_done=1 at t+1; stay in IDLE.
- SEND:
  - hold counter is loaded with HOLD_CYCLES-1 on each word launch and decrements each cycle.
  - At counter==0, if count>0: pop the next word; o_PE updates on the next edge.
  - At counter==0, if count==0: next cycle o_PE=MAX_INT, o_valid=0, o_done=1 for one cycle, state=IDLE.
  - Net effect: each word is visible for exactly HOLD_CYCLES cycles, back-to-back with no gaps.
  - Writes during SEND are accepted. A word written before the expiry check extends the stream.
  - i_start during SEND is ignored.
- i_stop (IDLE or SEND):
  - Next cycle: state=IDLE, o_PE=MAX_INT, o_valid=0, no o_done.
  - Unsent words stay in the FIFO.
  - i_stop wins over a simultaneous i_start.
- o_PE is always registered. There is no combinational path from inputs to o_PE.

Optional Feature:
NANCI_EDGE_TX_LOOP_EN
- Defined:
  - SEND is non-destructive: rd_ptr advances but count is not decremented.
  - After the last stored word, rd_ptr returns to the oldest entry and the stream repeats indefinitely.
  - SEND exits only through i_stop or rst; o_done never pulses from SEND.
  - o_full is forced to 1 during SEND, so writes are rejected and raise o_overflow.
  - On stop, rd_ptr is restored to the oldest entry and count is unchanged.
- Undefined: drain-once behaviour as specified above.

Test Plan:
- Reset/idle: hold rst 2 cycles, then idle -> o_PE=6'b111111, o_valid=0, o_empty=1, o_done=0.
- Basic drain (HOLD_CYCLES=1): write 6'b100000 then 6'b001000, pulse i_start at t:
  - o_PE=100000 at t+1 and 001000 at t+2.
  - o_PE=111111 with o_done=1 at t+3.
  - o_empty=1 after.
- Hold (HOLD_CYCLES=2): write 6'b011000, start at t:
  - o_PE=011000 for t+1..t+2.
  - MAX_INT with o_done at t+3.
- Full/overflow: write 9 words with DEPTH=8:
  - o_full=1 after the 8th.
  - The 9th is dropped and o_overflow=1.
  - Draining returns exactly words 1..8 in order.
- Abort and empty start:
  - i_stop on the 2nd cycle of a 3-word stream -> o_PE=111111 next cycle, no o_done, 1 word remains.
  - i_start with an empty FIFO -> o_done at t+1, o_valid stays 0.
- Loop (NANCI_EDGE_TX_LOOP_EN): write A,B, start:
  - o_PE sequence is A,B,A,B,...
  - A write during SEND sets o_overflow.
  - After i_stop, count=2.

Source files
------------

// File: rtl/nanci_edge_tx.sv
// nanci_edge_tx: transmit end of the PE neighbour link.
// Buffers scripted {addr,data} words in a circular FIFO. On i_start it plays
// them onto o_PE, holding each word for HOLD_CYCLES cycles. Between streams
// the link idles at MAX_INT so that idle slots sort last.
// Optional build macro NANCI_EDGE_TX_LOOP_EN: the stream replays the stored
// words forever without consuming them, until i_stop or rst.
module nanci_edge_tx #(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 3,
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 1,
  parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_wr_en,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_wr_word,
  input  logic                             i_start,
  input  logic                             i_stop,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
  output logic                             o_valid,
  output logic                             o_full,
  output logic                             o_empty,
  output logic                             o_overflow,
  output logic                             o_done
);
  localparam int W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_inc, base_ptr;
  logic [CW-1:0] count;
  logic [HW-1:0] hold, hold_nxt;
  logic          pop, load, clear, done_nxt, do_wr, pop_dec;

  assign o_empty = (count == '0);
  assign rd_inc  = rd_ptr + 1'b1;

`ifdef NANCI_EDGE_TX_LOOP_EN
  // Stored words are frozen while looping, so SEND refuses all writes.
  assign o_full  = (count == CW'(DEPTH)) || (state == SEND);
  assign pop_dec = 1'b0;
`else
  assign o_full  = (count == CW'(DEPTH));
  assign pop_dec = pop;
`endif

  assign do_wr = i_wr_en && !o_full;

  // Next-state and launch decisions; hold counter paces each word.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    pop       = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // i_stop outranks i_start; o_PE is already at MAX_INT here.
        if (i_start && !i_stop) begin
          if (count != '0) begin
            load      = 1'b1;
            pop       = 1'b1;
            hold_nxt  = HW'(HOLD_CYCLES - 1);
            state_nxt = SEND;
          end else begin
            done_nxt  = 1'b1;
          end
        end
      end
      SEND: begin
        if (i_stop) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end else if (hold != '0) begin
          hold_nxt  = hold - 1'b1;
        end else if (count != '0) begin
          load      = 1'b1;
          pop       = 1'b1;
          hold_nxt  = HW'(HOLD_CYCLES - 1);
        end else begin
          clear     = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= i_wr_word;
  end

  // FIFO bookkeeping, FSM state and the registered link outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      base_ptr   <= '0;
      count      <= '0;
      hold       <= '0;
      o_PE       <= MAX_INT;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state  <= state_nxt;
      hold   <= hold_nxt;
      o_done <= done_nxt;
      count  <= count + CW'(do_wr) - CW'(pop_dec);
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (i_wr_en && o_full) o_overflow <= 1'b1;
`ifdef NANCI_EDGE_TX_LOOP_EN
      // Launch from IDLE records the oldest entry; replay wraps back to it
      // after the newest word, and a stop rewinds to it.
      if (state == IDLE && pop) base_ptr <= rd_ptr;
      if (pop)
        rd_ptr <= (rd_inc == wr_ptr) ? ((state == IDLE) ? rd_ptr : base_ptr) : rd_inc;
      else if (state == SEND && i_stop)
        rd_ptr <= base_ptr;
`else
      if (pop) rd_ptr <= rd_inc;
`endif
      if (load) begin
        o_PE    <= mem[rd_ptr];
        o_valid <= 1'b1;
      end else if (clear) begin
        o_PE    <= MAX_INT;
        o_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nanci_edge_tx.sv
// Directed bench for nanci_edge_tx: dut uses HOLD_CYCLES=1, dut2 HOLD_CYCLES=2.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_nanci_edge_tx;
  logic       clk = 1'b0, rst = 1'b1;
  logic       wr_en = 1'b0, start = 1'b0, stop = 1'b0;
  logic       wr_en2 = 1'b0, start2 = 1'b0, stop2 = 1'b0;
  logic [5:0] wr_word = '0;
  logic [5:0] pe, pe2;
  logic       valid, full, empty, ovf, done;
  logic       valid2, full2, empty2, ovf2, done2;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  nanci_edge_tx #(.HOLD_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_word(wr_word),
    .i_start(start), .i_stop(stop), .o_PE(pe), .o_valid(valid),
    .o_full(full), .o_empty(empty), .o_overflow(ovf), .o_done(done));

  nanci_edge_tx #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en2), .i_wr_word(wr_word),
    .i_start(start2), .i_stop(stop2), .o_PE(pe2), .o_valid(valid2),
    .o_full(full2), .o_empty(empty2), .o_overflow(ovf2), .o_done(done2));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input logic [5:0] w);
    wr_word = w; wr_en = 1'b1; tick(); wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    checks++; if (pe !== 6'b111111) begin errors++; $display("FAIL reset_pe got=%b exp=111111", pe); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (pe2 !== 6'b111111) begin errors++; $display("FAIL reset_pe2 got=%b exp=111111", pe2); end
  endtask

  task automatic test_basic_drain();
    write_word(6'b100000); write_word(6'b001000);
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (pe !== 6'b100000 || valid !== 1'b1) begin errors++; $display("FAIL drain_w1 got=%b/%b exp=100000/1", pe, valid); end
    tick();
    checks++; if (pe !== 6'b001000 || valid !== 1'b1) begin errors++; $display("FAIL drain_w2 got=%b/%b exp=001000/1", pe, valid); end
    tick();
    checks++; if (pe !== 6'b111111 || done !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL drain_end got=%b done=%b valid=%b exp=111111 1 0", pe, done, valid); end
    tick();
    checks++; if (done !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL drain_after got done=%b empty=%b exp 0 1", done, empty); end
  endtask

  task automatic test_hold();
    wr_word = 6'b011000; wr_en2 = 1'b1; tick(); wr_en2 = 1'b0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    checks++; if (pe2 !== 6'b011000) begin errors++; $display("FAIL hold_t1 got=%b exp=011000", pe2); end
    tick();
    checks++; if (pe2 !== 6'b011000 || done2 !== 1'b0) begin errors++; $display("FAIL hold_t2 got=%b done=%b exp=011000 0", pe2, done2); end
    tick();
    checks++; if (pe2 !== 6'b111111 || done2 !== 1'b1) begin errors++; $display("FAIL hold_t3 got=%b done=%b exp=111111 1", pe2, done2); end
  endtask

  task automatic test_full_overflow();
    for (int i = 1; i <= 8; i++) write_word(6'(i * 6 + 3));
    checks++; if (full !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL full_8 got full=%b ovf=%b exp 1 0", full, ovf); end
    write_word(6'b111110);
    checks++; if (ovf !== 1'b1 || full !== 1'b1) begin errors++; $display("FAIL ovf_9 got ovf=%b full=%b exp 1 1", ovf, full); end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (pe !== 6'(i * 6 + 3)) begin errors++; $display("FAIL full_word%0d got=%b exp=%b", i, pe, 6'(i * 6 + 3)); end
      tick();
    end
    checks++; if (done !== 1'b1 || pe !== 6'b111111 || empty !== 1'b1) begin errors++; $display("FAIL full_end got done=%b pe=%b empty=%b exp 1 111111 1", done, pe, empty); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask

  task automatic test_abort();
    write_word(6'b000001); write_word(6'b000010); write_word(6'b000011);
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (pe !== 6'b000001) begin errors++; $display("FAIL abort_w1 got=%b exp=000001", pe); end
    tick();
    checks++; if (pe !== 6'b000010) begin errors++; $display("FAIL abort_w2 got=%b exp=000010", pe); end
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    checks++; if (pe !== 6'b111111 || valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_stop got pe=%b valid=%b done=%b exp 111111 0 0", pe, valid, done); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL abort_left got empty=%b exp=0", empty); end
    tick();
    checks++; if (done !== 1'b0 || pe !== 6'b111111) begin errors++; $display("FAIL abort_idle got done=%b pe=%b exp 0 111111", done, pe); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (pe !== 6'b000011) begin errors++; $display("FAIL abort_rest got=%b exp=000011", pe); end
    tick();
    checks++; if (done !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL abort_end got done=%b empty=%b exp 1 1", done, empty); end
  endtask

  task automatic test_empty_start();
    tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (done !== 1'b1 || valid !== 1'b0 || pe !== 6'b111111) begin errors++; $display("FAIL empty_start got done=%b valid=%b pe=%b exp 1 0 111111", done, valid, pe); end
    tick();
    checks++; if (done !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL empty_after got done=%b valid=%b exp 0 0", done, valid); end
  endtask

  task automatic test_back_to_back();
    write_word(6'b101010); write_word(6'b010101);
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (pe !== 6'b101010) begin errors++; $display("FAIL b2b_a got=%b exp=101010", pe); end
    wr_word = 6'b110011; wr_en = 1'b1; start = 1'b1; tick(); wr_en = 1'b0; start = 1'b0;
    checks++; if (pe !== 6'b010101) begin errors++; $display("FAIL b2b_b got=%b exp=010101", pe); end
    tick();
    checks++; if (pe !== 6'b110011 || valid !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_c got=%b valid=%b done=%b exp 110011 1 0", pe, valid, done); end
    tick();
    checks++; if (pe !== 6'b111111 || done !== 1'b1) begin errors++; $display("FAIL b2b_end got=%b done=%b exp 111111 1", pe, done); end
  endtask

  task automatic test_loop();
    write_word(6'b100000); write_word(6'b001000);
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (pe !== 6'b100000) begin errors++; $display("FAIL loop_a1 got=%b exp=100000", pe); end
    tick();
    checks++; if (pe !== 6'b001000) begin errors++; $display("FAIL loop_b1 got=%b exp=001000", pe); end
    tick();
    checks++; if (pe !== 6'b100000 || done !== 1'b0) begin errors++; $display("FAIL loop_a2 got=%b done=%b exp 100000 0", pe, done); end
    wr_word = 6'b000111; wr_en = 1'b1; tick(); wr_en = 1'b0;
    checks++; if (pe !== 6'b001000 || ovf !== 1'b1) begin errors++; $display("FAIL loop_wr got pe=%b ovf=%b exp 001000 1", pe, ovf); end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (pe !== 6'b111111 || valid !== 1'b0 || done !== 1'b0 || empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL loop_stop got pe=%b v=%b d=%b e=%b f=%b exp 111111 0 0 0 0", pe, valid, done, empty, full); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (pe !== 6'b100000) begin errors++; $display("FAIL loop_re_a got=%b exp=100000", pe); end
    tick();
    checks++; if (pe !== 6'b001000) begin errors++; $display("FAIL loop_re_b got=%b exp=001000", pe); end
    tick();
    checks++; if (pe !== 6'b100000) begin errors++; $display("FAIL loop_re_a2 got=%b exp=100000", pe); end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (done !== 1'b0 || pe !== 6'b111111) begin errors++; $display("FAIL loop_stop2 got done=%b pe=%b exp 0 111111", done, pe); end
  endtask

  initial begin
    test_reset();
`ifdef NANCI_EDGE_TX_LOOP_EN
    test_empty_start();
    test_loop();
`else
    test_basic_drain();
    test_hold();
    test_full_overflow();
    test_abort();
    test_empty_start();
    test_back_to_back();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
